pulse_period_meter: RTL and testbench

Receive-side companion to the team's loadable pulse counters. It watches a periodic single-bit `pulse` stream and measures the clock-cycle distance between consecutive rising edges. It reports each measured period with a one-cycle strobe and flags a stable (locked) stream. It also flags a missing pulse (overflow). Typical use: closing the loop on a `counter_8` style pulse generator, either in-system or as a self-checking monitor.

---
 rtl/pulse_period_meter.sv | 95 +++++++++
 tb/tb_pulse_period_meter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Measures the clock-cycle distance between consecutive rising edges of a pulse
// stream, strobes each period, and flags lock (repeat period) and missing pulses.
module pulse_period_meter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pulse,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVF  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state;
  logic             pulse_d;
  logic [WIDTH-1:0] cnt;
  logic             has_prev;
  logic             pulse_edge;

  // pulse_d resets high so a pulse held high through reset is not an edge
  assign pulse_edge = pulse & ~pulse_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pulse_d  <= 1'b1;
      cnt      <= '0;
      has_prev <= 1'b0;
      period   <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      pulse_d <= pulse;
      valid   <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        cnt      <= '0;
        has_prev <= 1'b0;
        locked   <= 1'b0;
        overflow <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (pulse_edge) begin
              state    <= RUN;
              cnt      <= {{(WIDTH-1){1'b0}}, 1'b1};
              has_prev <= 1'b0;
            end
          end
          RUN: begin
            if (pulse_edge) begin
              period   <= cnt;
              valid    <= 1'b1;
              cnt      <= {{(WIDTH-1){1'b0}}, 1'b1};
              locked   <= has_prev && (cnt == period);
              has_prev <= 1'b1;
            end else if (cnt == CNT_MAX) begin
              // counter saturated without an edge: the pulse went missing
              state    <= OVF;
              locked   <= 1'b0;
              overflow <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          OVF: begin
            if (pulse_edge) begin
              state    <= RUN;
              cnt      <= {{(WIDTH-1){1'b0}}, 1'b1};
              has_prev <= 1'b0;
              overflow <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter: an 8-bit instance for the main stream
// cases and a 4-bit instance for the overflow/saturation boundary.
module tb_pulse_period_meter;

  typedef struct packed {
    logic [7:0] p;
    logic       l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en8 = 1'b0, pulse8 = 1'b0;
  logic       en4 = 1'b0, pulse4 = 1'b0;
  logic [7:0] period8;
  logic [3:0] period4;
  logic       valid8, locked8, overflow8;
  logic       valid4, locked4, overflow4;

  exp_t q8[$];
  exp_t q4[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pulse_period_meter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .pulse(pulse8),
    .period(period8), .valid(valid8), .locked(locked8), .overflow(overflow8)
  );

  pulse_period_meter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .pulse(pulse4),
    .period(period4), .valid(valid4), .locked(locked4), .overflow(overflow4)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end else begin
      $display("check %s ok value=%0h", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hi_lo(input int h, input int l);
    pulse8 = 1'b1;
    repeat (h) tick();
    pulse8 = 1'b0;
    repeat (l) tick();
  endtask

  task automatic gap(input int n);
    hi_lo(1, n - 1);
  endtask

  task automatic restart8();
    en8 = 1'b0;
    pulse8 = 1'b0;
    repeat (2) tick();
    en8 = 1'b1;
  endtask

  task automatic push8(input int p, input logic l);
    exp_t e;
    e.p = p[7:0];
    e.l = l;
    q8.push_back(e);
  endtask

  // Monitors: every valid strobe pops one expected report
  always @(negedge clk) begin
    if (rst && valid8) begin
      checks++;
      if (q8.size() == 0) begin
        failures++;
        $display("FAIL dut8_unexpected_valid period=%0d locked=%0b", period8, locked8);
      end else begin
        exp_t e;
        e = q8.pop_front();
        if (period8 !== e.p || locked8 !== e.l) begin
          failures++;
          $display("FAIL dut8_report got period=%0d locked=%0b expected period=%0d locked=%0b",
                   period8, locked8, e.p, e.l);
        end else begin
          $display("report8 period=%0d locked=%0b ok", period8, locked8);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && valid4) begin
      checks++;
      if (q4.size() == 0) begin
        failures++;
        $display("FAIL dut4_unexpected_valid period=%0d locked=%0b", period4, locked4);
      end else begin
        exp_t e;
        e = q4.pop_front();
        if ({4'd0, period4} !== e.p || locked4 !== e.l) begin
          failures++;
          $display("FAIL dut4_report got period=%0d locked=%0b expected period=%0d locked=%0b",
                   period4, locked4, e.p, e.l);
        end else begin
          $display("report4 period=%0d locked=%0b ok", period4, locked4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e4;
    // reset values
    repeat (3) tick();
    check("rst_period8", {24'd0, period8}, 32'd0);
    check("rst_flags8", {29'd0, valid8, locked8, overflow8}, 32'd0);
    check("rst_period4", {28'd0, period4}, 32'd0);
    check("rst_flags4", {29'd0, valid4, locked4, overflow4}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // WIDTH=4: one edge then silence -> overflow after 16 cycles, no report
    en4 = 1'b1;
    tick();
    pulse4 = 1'b1;
    tick();
    pulse4 = 1'b0;
    repeat (14) tick();
    check("ovf4_before", {31'd0, overflow4}, 32'd0);
    tick();
    check("ovf4_rise", {31'd0, overflow4}, 32'd1);
    repeat (3) tick();
    check("ovf4_held", {31'd0, overflow4}, 32'd1);
    pulse4 = 1'b1;
    tick();
    check("ovf4_clear", {31'd0, overflow4}, 32'd0);
    pulse4 = 1'b0;
    e4.p = 8'd15;
    e4.l = 1'b0;
    q4.push_back(e4);
    repeat (14) tick();
    pulse4 = 1'b1;
    tick();
    check("sat4_report_valid", {31'd0, valid4}, 32'd1);
    pulse4 = 1'b0;
    tick();
    check("sat4_no_ovf", {31'd0, overflow4}, 32'd0);
    en4 = 1'b0;

    // steady 5-cycle stream, first report latency
    restart8();
    push8(5, 1'b0);
    repeat (4) push8(5, 1'b1);
    gap(5);
    pulse8 = 1'b1;
    tick();
    check("first_valid_timing", {23'd0, valid8, period8}, {23'd0, 1'b1, 8'd5});
    pulse8 = 1'b0;
    repeat (4) tick();
    repeat (4) gap(5);
    check("steady_no_ovf", {31'd0, overflow8}, 32'd0);
    check("steady_locked", {31'd0, locked8}, 32'd1);

    // spacing 5,5,7,7
    restart8();
    push8(5, 1'b0);
    push8(5, 1'b1);
    push8(7, 1'b0);
    push8(7, 1'b1);
    gap(5); gap(5); gap(7); gap(7); gap(3);

    // duty cycle: 3 high of 8
    restart8();
    push8(8, 1'b0);
    push8(8, 1'b1);
    repeat (3) hi_lo(3, 5);

    // minimum spacing alternating 1/0
    restart8();
    push8(2, 1'b0);
    repeat (3) push8(2, 1'b1);
    repeat (5) hi_lo(1, 1);
    tick();

    // long high counts as one edge
    restart8();
    push8(4, 1'b0);
    hi_lo(1, 3);
    hi_lo(20, 2);

    // en dropped mid-stream while edges arrive
    restart8();
    push8(6, 1'b0);
    push8(6, 1'b1);
    repeat (3) gap(6);
    check("pre_drop_locked", {31'd0, locked8}, 32'd1);
    en8 = 1'b0;
    pulse8 = 1'b1; tick();
    pulse8 = 1'b0; tick();
    pulse8 = 1'b1; tick();
    check("drop_locked_clear", {31'd0, locked8}, 32'd0);
    check("drop_period_hold", {24'd0, period8}, 32'd6);
    en8 = 1'b1;
    pulse8 = 1'b0;
    tick();
    push8(6, 1'b0);
    push8(6, 1'b1);
    gap(6); gap(6); gap(2);

    // async reset during locked RUN
    restart8();
    push8(5, 1'b0);
    push8(5, 1'b1);
    repeat (3) gap(5);
    check("pre_rst_locked", {31'd0, locked8}, 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    pulse8 = 1'b1;
    #1;
    check("async_rst_period", {24'd0, period8}, 32'd0);
    check("async_rst_flags", {29'd0, valid8, locked8, overflow8}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    check("held_high_no_valid", {31'd0, valid8}, 32'd0);
    pulse8 = 1'b0;
    tick();
    push8(5, 1'b0);
    push8(5, 1'b1);
    gap(5); gap(5); gap(2);

    repeat (5) tick();
    check("q8_drained", q8.size(), 32'd0);
    check("q4_drained", q4.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
